fifo_vc_umbral: RTL and testbench
=================================

Name: fifo_vc_umbral

Overview:
- Per-virtual-channel FIFO that feeds the flow-control FSM its status.
- Produces the FIFO_empty and FIFO_error inputs consumed by the FSM.
- Receives the FSM's registered threshold byte as umbral_VCFC:
  - [7:4] = almost-full threshold
  - [3:0] = almost-empty threshold
- Exports almost-full/almost-empty pause flags for the upstream sender and the downstream arbiter.

Parameters:
- DATA_WIDTH, 6, payload width per entry.
- ADDR_WIDTH, 4, pointer width. Depth = 2^ADDR_WIDTH = 16. Fixed at 4 so the threshold nibbles span the range.

Ports:
- clk  input  1  system clock; rising edge.
- reset  input  1  asynchronous, active-high reset.
- push  input  1  write request.
- data_in  input  DATA_WIDTH  write data.
- pop  input  1  read request.
- umbral_VCFC  input  8  thresholds: [7:4] almost-full level, [3:0] almost-empty level.
- data_out  output  DATA_WIDTH  registered read data.
- valid_out  output  1  one-cycle pulse; data_out holds the popped word.
- FIFO_empty  output  1  count == 0.
- FIFO_full  output  1  count == 16.
- FIFO_almost_full  output  1  count >= umbral_VCFC[7:4] and umbral_VCFC[7:4] != 0.
- FIFO_almost_empty  output  1  count <= umbral_VCFC[3:0].
- FIFO_error  output  1  sticky overflow/underflow flag.
- count  output  ADDR_WIDTH+1  current occupancy, 0..16.

Behaviour:
- Reset (async, high):
  - Pointers and count = 0.
  - data_out = 0, valid_out = 0, FIFO_error = 0.
  - FIFO_empty = 1, FIFO_full = 0, FIFO_almost_empty = 1.
  - FIFO_almost_full = 0.
  - Memory contents are not reset.
- Write:
  - On the rising edge with push=1 and not full, mem[wr_ptr] <= data_in and wr_ptr increments.
  - wr_ptr wraps 15 -> 0.
- Read:
  - On the rising edge with pop=1 and not empty, data_out <= mem[rd_ptr], rd_ptr increments and valid_out = 1 for that cycle.
  - Latency is one cycle: pop sampled at edge N gives data on data_out and valid_out after edge N.
  - data_out holds its last value when no pop is accepted; valid_out = 0.
- Count:
  - +1 on an accepted push only.
  - -1 on an accepted pop only.
  - Unchanged on both or neither.
- Simultaneous push and pop:
  - Empty: push accepted; pop is an underflow (error set); count becomes 1; valid_out = 0.
  - Full: both accepted, no error, count stays 16; data_out gets the oldest word.
  - Otherwise: both accepted, count unchanged.
- Overflow:
  - push while full and pop=0: data dropped, pointers unchanged, FIFO_error <= 1.
- Underflow:
  - pop while empty: pointers unchanged, valid_out = 0, data_out holds, FIFO_error <= 1.
- FIFO_error is sticky. Only reset clears it.
- Status flags:
  - All flags are combinational from the registered count and the current umbral_VCFC.
  - No extra latency beyond the count register.
  - A threshold change is reflected in the same cycle.
- Threshold edge cases:
  - umbral_VCFC[7:4] = 0 disables almost-full.
  - umbral_VCFC[3:0] = 0 makes almost-empty equal to empty.
- Reset mid-operation: all state returns to reset values immediately, without waiting for a clock edge. Queued data is discarded.

Test Plan:
- Reset asserted, then released with umbral_VCFC = 8'hC3, no traffic -> FIFO_empty = 1, FIFO_almost_empty = 1, FIFO_full = 0, FIFO_error = 0, count = 0.
- Push 0x01..0x10 (16 words) on consecutive cycles -> count steps 1..16:
  - FIFO_almost_empty drops when count reaches 4.
  - FIFO_almost_full rises when count reaches 12.
  - FIFO_full = 1 at 16.
- From full, push 0x3F with pop=0 -> FIFO_error = 1, count stays 16. Then pop 16 times -> data_out = 0x01..0x10 in order, one cycle after each pop, with valid_out pulsing each time; FIFO_error remains 1.
- From empty, pop and push 0x2A in the same cycle -> FIFO_error = 1, count = 1, valid_out = 0. Next cycle, pop -> data_out = 0x2A, valid_out = 1, FIFO_empty = 1.
- Fill to 16, then push 0x15 and pop in the same cycle -> count stays 16, no error, data_out = oldest word. Keep alternating for 20 cycles to exercise pointer wrap -> FIFO order preserved.
- Queue 5 words, assert reset between clock edges -> count = 0, FIFO_empty = 1, FIFO_error = 0 immediately. Change umbral_VCFC to 8'h05 at count = 3 -> FIFO_almost_full = 0 and FIFO_almost_empty = 1 in the same cycle.

Source files
------------

// File: rtl/fifo_vc_umbral.sv
// Per-virtual-channel FIFO that reports occupancy status to the flow-control FSM.
// Almost-full and almost-empty levels come from the FSM's threshold byte umbral_VCFC.
module fifo_vc_umbral #(
   parameter int DATA_WIDTH = 6,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  pop,
   input  logic [7:0]            umbral_VCFC,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid_out,
   output logic                  FIFO_empty,
   output logic                  FIFO_full,
   output logic                  FIFO_almost_full,
   output logic                  FIFO_almost_empty,
   output logic                  FIFO_error,
   output logic [ADDR_WIDTH:0]   count
);

   localparam int                  DEPTH    = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] CNT_ONE  = 1;
   localparam logic [ADDR_WIDTH:0] CNT_FULL = DEPTH[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [ADDR_WIDTH-1:0] wr_ptr_reg;
   logic [ADDR_WIDTH-1:0] rd_ptr_reg;
   logic [ADDR_WIDTH:0]   count_reg;
   logic [ADDR_WIDTH:0]   count_next;
   logic [DATA_WIDTH-1:0] data_reg;
   logic                  valid_reg;
   logic                  error_reg;

   logic                  empty_flag;
   logic                  full_flag;
   logic                  push_ok;
   logic                  pop_ok;
   logic                  fault;
   logic [ADDR_WIDTH:0]   thr_full;
   logic [ADDR_WIDTH:0]   thr_empty;

   assign empty_flag = (count_reg == '0);
   assign full_flag  = (count_reg == CNT_FULL);

   // A push into a full FIFO is still taken when a pop frees the slot in the same cycle.
   assign push_ok = push && (!full_flag || pop);
   assign pop_ok  = pop && !empty_flag;
   assign fault   = (push && full_flag && !pop) || (pop && empty_flag);

   always_comb begin
      count_next = count_reg;
      if (push_ok && !pop_ok) begin
         count_next = count_reg + CNT_ONE;
      end else if (pop_ok && !push_ok) begin
         count_next = count_reg - CNT_ONE;
      end
   end

   // Storage is deliberately left out of reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_reg] <= data_in;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         data_reg   <= '0;
         valid_reg  <= 1'b0;
         error_reg  <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         end
         if (pop_ok) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            data_reg   <= mem[rd_ptr_reg];
         end
         valid_reg <= pop_ok;
         if (fault) begin
            error_reg <= 1'b1;
         end
         count_reg <= count_next;
      end
   end

   // Thresholds are applied combinationally so a new umbral_VCFC acts in the same cycle.
   assign thr_full  = {1'b0, umbral_VCFC[7:4]};
   assign thr_empty = {1'b0, umbral_VCFC[3:0]};

   assign data_out          = data_reg;
   assign valid_out         = valid_reg;
   assign count             = count_reg;
   assign FIFO_empty        = empty_flag;
   assign FIFO_full         = full_flag;
   assign FIFO_error        = error_reg;
   assign FIFO_almost_full  = (thr_full != '0) && (count_reg >= thr_full);
   assign FIFO_almost_empty = (count_reg <= thr_empty);

endmodule

// File: tb/tb_fifo_vc_umbral.sv
// Self-checking bench for fifo_vc_umbral: table-driven fill/overflow/drain plus
// hand-written sequences for simultaneous access, pointer wrap and async reset.
module tb_fifo_vc_umbral;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       push = 1'b0;
   logic [5:0] data_in = '0;
   logic       pop = 1'b0;
   logic [7:0] umbral_VCFC = 8'hC3;
   logic [5:0] data_out;
   logic       valid_out;
   logic       FIFO_empty;
   logic       FIFO_full;
   logic       FIFO_almost_full;
   logic       FIFO_almost_empty;
   logic       FIFO_error;
   logic [4:0] count;

   fifo_vc_umbral #(.DATA_WIDTH(6), .ADDR_WIDTH(4)) dut (
      .clk(clk),
      .reset(reset),
      .push(push),
      .data_in(data_in),
      .pop(pop),
      .umbral_VCFC(umbral_VCFC),
      .data_out(data_out),
      .valid_out(valid_out),
      .FIFO_empty(FIFO_empty),
      .FIFO_full(FIFO_full),
      .FIFO_almost_full(FIFO_almost_full),
      .FIFO_almost_empty(FIFO_almost_empty),
      .FIFO_error(FIFO_error),
      .count(count)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         push;
      bit         pop;
      logic [5:0] data;
      int         count;
      bit         empty;
      bit         full;
      bit         af;
      bit         ae;
      bit         err;
   } vec_t;

   vec_t       vt [33];
   logic [5:0] mq [$];
   logic [5:0] sb [$];
   bit         m_err;
   int         checks = 0;
   int         errors = 0;
   int         txn = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_model(input string tag);
      int n;
      int hi;
      int lo;
      n  = mq.size();
      hi = int'(umbral_VCFC[7:4]);
      lo = int'(umbral_VCFC[3:0]);
      chk({tag, " count"}, int'(count), n);
      chk({tag, " empty"}, int'(FIFO_empty), int'(n == 0));
      chk({tag, " full"}, int'(FIFO_full), int'(n == 16));
      chk({tag, " error"}, int'(FIFO_error), int'(m_err));
      chk({tag, " almost_full"}, int'(FIFO_almost_full), int'(hi != 0 && n >= hi));
      chk({tag, " almost_empty"}, int'(FIFO_almost_empty), int'(n <= lo));
   endtask

   // Called at a falling edge; drives one cycle and samples at the next falling edge.
   task automatic apply(input bit p, input bit q, input logic [5:0] d);
      bit m_full;
      bit m_empty;
      bit exp_valid;
      logic [5:0] want;
      m_full    = (mq.size() == 16);
      m_empty   = (mq.size() == 0);
      exp_valid = q && !m_empty;
      if (exp_valid) sb.push_back(mq.pop_front());
      if (p && (!m_full || q)) mq.push_back(d);
      if ((p && m_full && !q) || (q && m_empty)) m_err = 1'b1;
      push = p;
      pop = q;
      data_in = d;
      @(posedge clk);
      @(negedge clk);
      txn++;
      $display("txn %0d: push=%0b pop=%0b din=%02h -> count=%0d valid=%0b dout=%02h err=%0b",
               txn, p, q, d, count, valid_out, data_out, FIFO_error);
      chk($sformatf("txn%0d valid_out", txn), int'(valid_out), int'(exp_valid));
      if (valid_out) begin
         if (sb.size() == 0) begin
            chk($sformatf("txn%0d unexpected valid", txn), 1, 0);
         end else begin
            want = sb.pop_front();
            chk($sformatf("txn%0d data_out", txn), int'(data_out), int'(want));
         end
      end else if (exp_valid) begin
         void'(sb.pop_front());
      end
      push = 1'b0;
      pop = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      mq.delete();
      sb.delete();
      m_err = 1'b0;
   endtask

   initial begin
      // Fill, overflow while full, then drain; expectations follow the flag definitions.
      for (int i = 0; i < 16; i++) begin
         vt[i].push = 1'b1; vt[i].pop = 1'b0; vt[i].data = 6'(i + 1);
         vt[i].count = i + 1; vt[i].empty = 1'b0; vt[i].full = ((i + 1) == 16);
         vt[i].af = ((i + 1) >= 12); vt[i].ae = ((i + 1) <= 3); vt[i].err = 1'b0;
      end
      vt[16].push = 1'b1; vt[16].pop = 1'b0; vt[16].data = 6'h3F; vt[16].count = 16;
      vt[16].empty = 1'b0; vt[16].full = 1'b1; vt[16].af = 1'b1; vt[16].ae = 1'b0;
      vt[16].err = 1'b1;
      for (int k = 0; k < 16; k++) begin
         vt[17 + k].push = 1'b0; vt[17 + k].pop = 1'b1; vt[17 + k].data = 6'h00;
         vt[17 + k].count = 15 - k; vt[17 + k].empty = ((15 - k) == 0);
         vt[17 + k].full = 1'b0; vt[17 + k].af = ((15 - k) >= 12);
         vt[17 + k].ae = ((15 - k) <= 3); vt[17 + k].err = 1'b1;
      end

      m_err = 1'b0;
      umbral_VCFC = 8'hC3;
      do_reset();
      chk("reset empty", int'(FIFO_empty), 1);
      chk("reset almost_empty", int'(FIFO_almost_empty), 1);
      chk("reset full", int'(FIFO_full), 0);
      chk("reset almost_full", int'(FIFO_almost_full), 0);
      chk("reset error", int'(FIFO_error), 0);
      chk("reset count", int'(count), 0);
      chk("reset valid_out", int'(valid_out), 0);
      chk("reset data_out", int'(data_out), 0);

      for (int i = 0; i < 33; i++) begin
         apply(vt[i].push, vt[i].pop, vt[i].data);
         chk($sformatf("vec%0d count", i), int'(count), vt[i].count);
         chk($sformatf("vec%0d empty", i), int'(FIFO_empty), int'(vt[i].empty));
         chk($sformatf("vec%0d full", i), int'(FIFO_full), int'(vt[i].full));
         chk($sformatf("vec%0d almost_full", i), int'(FIFO_almost_full), int'(vt[i].af));
         chk($sformatf("vec%0d almost_empty", i), int'(FIFO_almost_empty), int'(vt[i].ae));
         chk($sformatf("vec%0d error", i), int'(FIFO_error), int'(vt[i].err));
      end

      // Simultaneous push and pop on an empty FIFO: push taken, pop is an underflow.
      do_reset();
      apply(1'b1, 1'b1, 6'h2A);
      chk("empty pushpop error", int'(FIFO_error), 1);
      chk("empty pushpop count", int'(count), 1);
      chk("empty pushpop valid_out", int'(valid_out), 0);
      chk("empty pushpop data_out held", int'(data_out), 0);
      apply(1'b0, 1'b1, 6'h00);
      chk("pop 2A data_out", int'(data_out), 8'h2A);
      chk("pop 2A empty", int'(FIFO_empty), 1);

      // Full with concurrent push and pop, running long enough to wrap both pointers.
      do_reset();
      for (int i = 0; i < 16; i++) apply(1'b1, 1'b0, 6'($urandom_range(0, 63)));
      check_model("filled");
      for (int i = 0; i < 20; i++) begin
         apply(1'b1, 1'b1, 6'(8'h15 + i));
         check_model($sformatf("wrap%0d", i));
      end
      for (int i = 0; i < 16; i++) apply(1'b0, 1'b1, 6'h00);
      check_model("drained");

      // Asynchronous reset between edges, then a same-cycle threshold change.
      do_reset();
      umbral_VCFC = 8'h32;
      apply(1'b0, 1'b1, 6'h00);
      check_model("underflow");
      for (int i = 0; i < 5; i++) apply(1'b1, 1'b0, 6'(i + 7));
      check_model("queued5");
      #2 reset = 1'b1;
      #1;
      chk("async reset count", int'(count), 0);
      chk("async reset empty", int'(FIFO_empty), 1);
      chk("async reset error", int'(FIFO_error), 0);
      chk("async reset valid_out", int'(valid_out), 0);
      @(negedge clk);
      reset = 1'b0;
      mq.delete();
      sb.delete();
      m_err = 1'b0;
      for (int i = 0; i < 3; i++) apply(1'b1, 1'b0, 6'(i + 1));
      chk("thr 32 almost_full", int'(FIFO_almost_full), 1);
      chk("thr 32 almost_empty", int'(FIFO_almost_empty), 0);
      #2 umbral_VCFC = 8'h05;
      #1;
      chk("thr 05 almost_full", int'(FIFO_almost_full), 0);
      chk("thr 05 almost_empty", int'(FIFO_almost_empty), 1);
      chk("thr 05 count", int'(count), 3);
      @(negedge clk);
      for (int i = 0; i < 3; i++) apply(1'b0, 1'b1, 6'h00);
      check_model("final");
      chk("scoreboard drained", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
